// File: rtl/pie_encoder_pkg.sv
// Shared definitions for the PIE encoder.
// Holds the FSM state encoding and the default Gen2-style timing constants
// (all in clock cycles). Tag-side benches import the same timing constants so
// that both ends of the link agree on symbol lengths.
package pie_encoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELIM = 3'd1,
        ST_DATA0 = 3'd2,
        ST_RTCAL = 3'd3,
        ST_TRCAL = 3'd4,
        ST_DATA  = 3'd5
    } pie_state_e;

    localparam int PIE_CW    = 10;
    localparam int PIE_DELIM = 12;
    localparam int PIE_PW    = 12;
    localparam int PIE_TARI  = 25;
    localparam int PIE_DATA1 = 45;
    localparam int PIE_RTCAL = 70;   // TARI + DATA1
    localparam int PIE_TRCAL = 150;  // tag counters saturate above 750

endpackage

// File: rtl/pie_encoder_if.sv
// Frame-request / bit-stream / waveform bundle of the PIE encoder.
//   master : frame source (drives start, preamble and the bit stream)
//   slave  : the encoder (returns bit_ready, pie_out and frame status)
interface pie_encoder_if;
    logic start;      // frame request, sampled only while idle
    logic preamble;   // sampled with start; 1 inserts TRcal
    logic bit_in;     // data bit
    logic bit_last;   // marks final data bit
    logic bit_valid;  // bit_in / bit_last valid
    logic bit_ready;  // encoder takes the bit this cycle
    logic pie_out;    // PIE waveform, idle high
    logic busy;       // frame in progress
    logic done;       // one-cycle pulse, frame completed
    logic underrun;   // one-cycle pulse, frame aborted for lack of data

    modport master (
        output start, preamble, bit_in, bit_last, bit_valid,
        input  bit_ready, pie_out, busy, done, underrun
    );

    modport slave (
        input  start, preamble, bit_in, bit_last, bit_valid,
        output bit_ready, pie_out, busy, done, underrun
    );
endinterface

// File: rtl/pie_symbol_timer.sv
// Symbol timer for the PIE encoder.
// A CW-bit up-counter that runs 0..L-1 for a symbol of length L. The symbol
// is high for L-low cycles and then low for `low` cycles; the phase output is
// registered so the waveform leaves the block glitch-free.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clr_i        return to idle: counter 0, phase high
//   load_i       start a new symbol of length len_i with low_i low cycles
//   len_i, low_i symbol length and low-pulse width (low_i == len_i: all low)
//   tc_o         terminal count (counter == L-1)
//   high_o       current phase, 1 = high
module pie_symbol_timer #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] len_i,
    input  logic [CW-1:0] low_i,
    output logic          tc_o,
    output logic          high_o
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] hi_len_q;   // number of leading high cycles
    logic          high_q;
    logic [CW-1:0] cnt_inc_s;

    assign cnt_inc_s = cnt_q + ONE;
    assign tc_o      = (cnt_q == (len_q - ONE));
    assign high_o    = high_q;

    // Counter and phase register; the phase is computed from the count the
    // counter is about to hold so it lines up with that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= {CW{1'b0}};
            len_q    <= {CW{1'b0}};
            hi_len_q <= {CW{1'b0}};
            high_q   <= 1'b1;
        end else if (clr_i) begin
            cnt_q    <= {CW{1'b0}};
            len_q    <= {CW{1'b0}};
            hi_len_q <= {CW{1'b0}};
            high_q   <= 1'b1;
        end else if (load_i) begin
            cnt_q    <= {CW{1'b0}};
            len_q    <= len_i;
            hi_len_q <= len_i - low_i;
            high_q   <= (low_i < len_i);
        end else begin
            cnt_q    <= cnt_inc_s;
            high_q   <= (cnt_inc_s < hi_len_q);
        end
    end

endmodule

// File: rtl/pie_encoder.sv
// Reader-side PIE frame transmitter.
// Emits delimiter, data-0, RTcal, optional TRcal, then one symbol per data
// bit taken over a valid/ready handshake. Symbols abut with no gap cycles.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         pie_encoder_if.slave (start/preamble, bit stream, pie_out,
//               busy, done, underrun)
module pie_encoder
    import pie_encoder_pkg::*;
#(
    parameter int CW    = PIE_CW,
    parameter int DELIM = PIE_DELIM,
    parameter int PW    = PIE_PW,
    parameter int TARI  = PIE_TARI,
    parameter int DATA1 = PIE_DATA1,
    parameter int RTCAL = PIE_RTCAL,
    parameter int TRCAL = PIE_TRCAL
) (
    input  logic        clk,
    input  logic        reset,
    pie_encoder_if.slave bus
);

    localparam logic [CW-1:0] L_DELIM = CW'(DELIM);
    localparam logic [CW-1:0] L_PW    = CW'(PW);
    localparam logic [CW-1:0] L_TARI  = CW'(TARI);
    localparam logic [CW-1:0] L_DATA1 = CW'(DATA1);
    localparam logic [CW-1:0] L_RTCAL = CW'(RTCAL);
    localparam logic [CW-1:0] L_TRCAL = CW'(TRCAL);

    pie_state_e    state_q, state_d;
    logic          pre_q;
    logic          last_q;
    logic          busy_q;
    logic          done_q, done_d;
    logic          underrun_q, underrun_d;
    logic          take_s;
    logic          clr_s;
    logic          load_s;
    logic [CW-1:0] len_s;
    logic [CW-1:0] low_s;
    logic          tc_s;
    logic          high_s;
    logic          bit_ready_s;

    pie_symbol_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (clr_s),
        .load_i (load_s),
        .len_i  (len_s),
        .low_i  (low_s),
        .tc_o   (tc_s),
        .high_o (high_s)
    );

    // A bit is fetched at the end of the last calibration symbol and at the
    // end of every non-final data symbol. RTcal only fetches when no TRcal
    // follows it.
    assign bit_ready_s = tc_s &&
                         (((state_q == ST_RTCAL) && !pre_q) ||
                          (state_q == ST_TRCAL) ||
                          ((state_q == ST_DATA) && !last_q));

    assign bus.bit_ready = bit_ready_s;
    assign bus.pie_out   = high_s;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.underrun  = underrun_q;

    // Next-state and timer-control decode.
    always_comb begin
        state_d    = state_q;
        clr_s      = 1'b0;
        load_s     = 1'b0;
        len_s      = L_TARI;
        low_s      = L_PW;
        done_d     = 1'b0;
        underrun_d = 1'b0;
        take_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_DELIM;
                    load_s  = 1'b1;
                    len_s   = L_DELIM;
                    low_s   = L_DELIM;   // delimiter is low throughout
                end else begin
                    clr_s   = 1'b1;
                end
            end
            ST_DELIM: begin
                if (tc_s) begin
                    state_d = ST_DATA0;
                    load_s  = 1'b1;
                    len_s   = L_TARI;
                end else begin
                    load_s  = 1'b0;
                end
            end
            ST_DATA0: begin
                if (tc_s) begin
                    state_d = ST_RTCAL;
                    load_s  = 1'b1;
                    len_s   = L_RTCAL;
                end else begin
                    load_s  = 1'b0;
                end
            end
            ST_RTCAL: begin
                // Without a preamble the terminal count is a fetch cycle,
                // handled below.
                if (tc_s && pre_q) begin
                    state_d = ST_TRCAL;
                    load_s  = 1'b1;
                    len_s   = L_TRCAL;
                end else begin
                    load_s  = 1'b0;
                end
            end
            ST_TRCAL: begin
                load_s = 1'b0;
            end
            ST_DATA: begin
                if (tc_s && last_q) begin
                    state_d = ST_IDLE;
                    clr_s   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    load_s  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                clr_s   = 1'b1;
            end
        endcase

        if (bit_ready_s) begin
            if (bus.bit_valid) begin
                state_d = ST_DATA;
                load_s  = 1'b1;
                take_s  = 1'b1;
                len_s   = bus.bit_in ? L_DATA1 : L_TARI;
                low_s   = L_PW;
            end else begin
                state_d    = ST_IDLE;
                clr_s      = 1'b1;
                load_s     = 1'b0;
                underrun_d = 1'b1;
            end
        end else begin
            take_s = 1'b0;
        end
    end

    // FSM state, latched frame options and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pre_q      <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            if ((state_q == ST_IDLE) && bus.start) begin
                pre_q  <= bus.preamble;
            end
            if (take_s) begin
                last_q <= bus.bit_last;
            end
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_pie_encoder.sv
// Directed bench for pie_encoder: frame waveforms checked as run lengths of
// pie_out against hand-computed symbol timings.
module tb_pie_encoder;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pie_encoder_if bus ();

    pie_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic pie_w   [0:399];
    logic done_w  [0:399];
    logic busy_w  [0:399];
    logic und_w   [0:399];
    logic ready_w [0:399];
    logic seq     [0:1];

    int exp_np [0:8]  = '{12, 13, 12, 58, 12, 13, 12, 33, 12};
    int exp_pr [0:10] = '{12, 13, 12, 58, 12, 138, 12, 13, 12, 33, 12};

    // Issue start at a negedge, then record outputs for cycles 1..ncyc after
    // the start edge; feeds bits {0, 1(last)} when vld is set.
    task automatic capture(input bit pre, input bit vld, input int ncyc,
                           input int mid_start, input int restart);
        int idx;
        idx = 0;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.preamble  = pre;
        bus.bit_valid = vld;
        bus.bit_in    = seq[0];
        bus.bit_last  = 1'b0;
        @(posedge clk);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            bus.start  = (k == mid_start) || (k == restart);
            pie_w[k]   = bus.pie_out;
            done_w[k]  = bus.done;
            busy_w[k]  = bus.busy;
            und_w[k]   = bus.underrun;
            ready_w[k] = bus.bit_ready;
            if (bus.done) idx = 0;
            bus.bit_in   = seq[idx];
            bus.bit_last = (idx == 1);
            if (bus.bit_ready && bus.bit_valid && idx < 1) idx++;
        end
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    task automatic get_runs(input int lo, input int hi, output int n,
                            output int r [0:15]);
        logic cur;
        int   len;
        for (int i = 0; i < 16; i++) r[i] = 0;
        n   = 0;
        cur = pie_w[lo];
        len = 1;
        for (int i = lo + 1; i <= hi; i++) begin
            if (pie_w[i] === cur) begin
                len++;
            end else begin
                if (n < 16) r[n] = len;
                n++;
                cur = pie_w[i];
                len = 1;
            end
        end
        if (n < 16) r[n] = len;
        n++;
    endtask

    function automatic int first_done(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) if (done_w[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic check_np_frame(input string tag, input int base);
        int n;
        int r [0:15];
        int d;
        get_runs(base + 1, base + 177, n, r);
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL %s run_count: got %0d want 9", tag, n);
        end
        checks++;
        if (pie_w[base + 1] !== 1'b0) begin
            errors++;
            $display("FAIL %s first_low: got %b want 0", tag, pie_w[base + 1]);
        end
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (r[i] !== exp_np[i]) begin
                errors++;
                $display("FAIL %s run%0d: got %0d want %0d", tag, i, r[i], exp_np[i]);
            end
        end
        d = first_done(base + 1, base + 200);
        checks++;
        if (d !== base + 178) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want %0d", tag, d - base, 178);
        end
        checks++;
        if (busy_w[base + 177] !== 1'b1 || busy_w[base + 178] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_end: got %b%b want 10", tag,
                     busy_w[base + 177], busy_w[base + 178]);
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.preamble  = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_last  = 1'b0;
        bus.bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.pie_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_pie: got %b want 1", bus.pie_out);
        end
        checks++;
        if ({bus.busy, bus.done, bus.underrun, bus.bit_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {bus.busy, bus.done, bus.underrun, bus.bit_ready});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_nopre();
        capture(1'b0, 1'b1, 185, 0, 0);
        check_np_frame("nopre", 0);
    endtask

    task automatic test_frame_pre();
        int n;
        int r [0:15];
        int d;
        capture(1'b1, 1'b1, 335, 0, 0);
        get_runs(1, 327, n, r);
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL pre run_count: got %0d want 11", n);
        end
        for (int i = 0; i < 11; i++) begin
            checks++;
            if (r[i] !== exp_pr[i]) begin
                errors++;
                $display("FAIL pre run%0d: got %0d want %0d", i, r[i], exp_pr[i]);
            end
        end
        d = first_done(1, 335);
        checks++;
        if (d !== 328) begin
            errors++;
            $display("FAIL pre done_cycle: got %0d want 328", d);
        end
    endtask

    task automatic test_underrun();
        capture(1'b0, 1'b0, 130, 0, 0);
        checks++;
        if (ready_w[107] !== 1'b1 || pie_w[107] !== 1'b0) begin
            errors++;
            $display("FAIL und_ready: got ready=%b pie=%b want 1 0", ready_w[107], pie_w[107]);
        end
        checks++;
        if ({und_w[108], busy_w[108], pie_w[108]} !== 3'b101) begin
            errors++;
            $display("FAIL und_pulse: got %b want 101", {und_w[108], busy_w[108], pie_w[108]});
        end
        checks++;
        if (und_w[107] !== 1'b0 || und_w[109] !== 1'b0) begin
            errors++;
            $display("FAIL und_width: got %b%b want 00", und_w[107], und_w[109]);
        end
        for (int k = 108; k <= 130; k++) begin
            if (pie_w[k] !== 1'b1 || done_w[k] !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL und_idle: cycle %0d pie=%b done=%b want 1 0", k, pie_w[k], done_w[k]);
                break;
            end
        end
        checks++;
        if (pie_w[130] !== 1'b1) begin
            errors++;
            $display("FAIL und_tail: got %b want 1", pie_w[130]);
        end
    endtask

    task automatic test_start_ignored();
        capture(1'b0, 1'b1, 185, 50, 0);
        check_np_frame("midstart", 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.preamble = 1'b0;
        @(posedge clk);
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.pie_out !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got pie=%b busy=%b want 0 1", bus.pie_out, bus.busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.pie_out, bus.busy, bus.bit_ready, bus.done, bus.underrun} !== 5'b10000) begin
            errors++;
            $display("FAIL rstmid_out: got %b want 10000",
                     {bus.pie_out, bus.busy, bus.bit_ready, bus.done, bus.underrun});
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (bus.pie_out !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_idle: got pie=%b busy=%b want 1 0", bus.pie_out, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        capture(1'b0, 1'b1, 360, 0, 178);
        checks++;
        if (done_w[178] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: got %b want 1", done_w[178]);
        end
        checks++;
        if (pie_w[179] !== 1'b0 || busy_w[179] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got pie=%b busy=%b want 0 1", pie_w[179], busy_w[179]);
        end
        check_np_frame("b2b2", 178);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        seq[0] = 1'b0;
        seq[1] = 1'b1;
        test_reset();
        test_frame_nopre();
        test_frame_pre();
        test_underrun();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pie_encoder.md
# pie_encoder

Reader-side transmitter for the tag's PIE receiver. Emits Gen2-style pulse-interval-encoded frames on `pie_out`: a delimiter, data-0 and RTcal, optionally TRcal, then a stream of data symbols supplied over a valid/ready handshake. All durations are integer clock-cycle counts. The block drives bench and emulator stimulus for the tag's 10-bit interval-measurement counters.

## Interface
- `CW`, 10: symbol counter width.
- `DELIM`, 12: delimiter low time, in cycles.
- `PW`, 12: low-pulse width ending every symbol.
- `TARI`, 25: data-0 symbol length.
- `DATA1`, 45: data-1 symbol length.
- `RTCAL`, 70: RTcal length; equals TARI + DATA1.
- `TRCAL`, 150: TRcal length.
- Parameter constraints: PW < TARI < DATA1 < RTCAL; all values ≥ 1. TRCAL ≤ 750, because tag measurement counters saturate above 750.
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `start` in 1: frame request, sampled only in IDLE.
- `preamble` in 1: sampled with `start`; 1 inserts TRcal.
- `bit_in` in 1: data bit.
- `bit_last` in 1: marks the final data bit.
- `bit_valid` in 1: `bit_in`/`bit_last` valid.
- `bit_ready` out 1: encoder takes the bit this cycle.
- `pie_out` out 1: PIE waveform; idle high.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse, frame completed normally.
- `underrun` out 1: one-cycle pulse, frame aborted for lack of data.

## Operation
- States: IDLE, DELIM, DATA0, RTCAL, TRCAL, DATA.
- Symbol of length L: `pie_out` high for L−PW cycles, then low for PW cycles. Counter runs 0..L−1; terminal count is L−1.
- IDLE: `pie_out`=1, `busy`=0.
  - `start`=1 → DELIM. Latch `preamble`.
- DELIM: `pie_out`=0 for DELIM cycles → DATA0.
- DATA0: symbol of length TARI → RTCAL.
- RTCAL: symbol of length RTCAL.
  - If `preamble` latched → TRCAL.
  - Otherwise → DATA.
- TRCAL: symbol of length TRCAL → DATA.
- DATA: symbol length is TARI for bit 0, DATA1 for bit 1.
- Bit fetch:
  - `bit_ready`=1 for exactly one cycle: the terminal-count cycle of RTCAL/TRCAL, and of each DATA symbol whose bit was not last.
  - Transfer occurs on `bit_valid & bit_ready`. The bit is latched and its symbol starts the next cycle.
  - `bit_ready` with `bit_valid`=0 is an underrun:
    - next state IDLE;
    - `underrun` pulses the next cycle;
    - `pie_out` returns high.
  - Terminal count of the symbol for a bit with `bit_last`=1 → IDLE, with `done` pulsed in the first IDLE cycle.
- `start` while `busy` is ignored. `bit_valid` outside `bit_ready` is ignored.
- Reset, including mid-frame: state IDLE, counter 0, `pie_out`=1, `busy`=0, `bit_ready`=0, `done`=0, `underrun`=0. Outputs take these values in the cycle after reset is sampled.

## Timing
- All outputs are registered, except `bit_ready`, which is decoded from state and counter registers.
- `start` sampled at edge t → `pie_out`=0 and `busy`=1 from t+1.
- Consecutive symbols abut with no gap cycles.
- Frame length in cycles: DELIM + TARI + RTCAL + (TRCAL if preamble) + Σ data symbol lengths.
- `done`/`underrun` coincide with the first IDLE cycle (`busy`=0). `start` is accepted in that same cycle.

## Structure
- Shared package holds:
  - state encoding constants;
  - default timing constants (DELIM, PW, TARI, DATA1, RTCAL, TRCAL), reused by tag-side benches.
- Sub-module `pie_symbol_timer`:
  - CW-bit up-counter with synchronous clear/load of length L;
  - outputs terminal-count and high/low phase;
  - reset is synchronous, active-high.

## Test plan
- Reset: hold `reset` 3 cycles → `pie_out`=1; `busy`, `done`, `underrun`, `bit_ready`=0.
- `start`, `preamble`=0, bits {0, 1(last)}, `bit_valid` held high:
  - `pie_out` low 12;
  - then high 13 / low 12;
  - then high 58 / low 12;
  - then high 13 / low 12;
  - then high 33 / low 12;
  - `done` at cycle 178 after the start edge.
- Same frame with `preamble`=1 → TRcal high 138 / low 12 inserted after RTcal; `done` at cycle 328.
- `bit_valid`=0 at the first `bit_ready` → `underrun` pulse, `busy`=0, `pie_out`=1 the next cycle; no data symbol emitted.
- Boundary conditions:
  - `start` pulsed mid-frame → ignored, waveform unchanged;
  - `reset` asserted during DELIM → `pie_out`=1 next cycle, state IDLE;
  - `start` in the `done` cycle → new delimiter begins the following cycle.
